nw_control_unit: RTL and testbench
==================================

Name: nw_control_unit

Overview:
Moore FSM that sequences the Needleman-Wunsch datapath through its four phases: matrix init, cell fill (read / compute / write / advance), traceback, and done.
- Drives the datapath enables: en_init, en_read, en_ins, we, change_index, en_traceB.
- Consumes the datapath status flags.
- Gives the host a start/busy/done/error handshake.
- Includes a phase watchdog and a cell-count consistency check.

Parameters:
N, 128, sequence length; the fill phase covers N*N cells.
TIMEOUT, 1024, maximum cycles allowed in one waiting state before an error.
CELL_W, $clog2(N*N+1), width of the cell counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  host pulse that launches an alignment (also clears error)
abort  in  1  host request to return to IDLE
end_init  in  1  datapath: first row/column initialisation finished
calculated  in  1  datapath: diag/up/left read, max and symbol valid
end_filling  in  1  datapath: last cell written
end_c  in  1  datapath: traceback reached (0,0)
en_init  out  1  datapath init enable
en_read  out  1  score read enable
en_ins  out  1  insert enable (score and direction)
we  out  1  RAM write strobe
change_index  out  1  advance i/j to the next cell
en_traceB  out  1  traceback enable
busy  out  1  high from INIT through TRACE
done  out  1  one-cycle completion pulse
error  out  1  sticky fault flag
cell_cnt  out  CELL_W  cells written in the current run
cycle_count  out  32  cycles from start to done (optional feature)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; cell_cnt=0; watchdog=0; cycle_count=0.
  - All outputs 0.
  - Reset mid-operation aborts immediately; enables are 0 in the next cycle.
- Outputs are a pure decode of the state register (Moore). A transition sampled at edge k changes the outputs after edge k.
- State decodes and transitions:
  - IDLE: all enables 0. start -> INIT. Entering INIT clears error and cell_cnt.
  - INIT: en_init=1. end_init -> READ.
  - READ: en_read=1. calculated -> WRITE.
  - WRITE: en_ins=1, we=1, exactly one cycle; cell_cnt increments.
    - If end_filling=1 in this cycle: go to TRACE when cell_cnt+1==N*N, otherwise to ERROR.
    - Else: go to NEXT.
  - NEXT: change_index=1 for one cycle.
    - If cell_cnt==N*N, go to ERROR (end_filling was missed).
    - Else go to READ.
  - TRACE: en_traceB=1. end_c -> DONE.
  - DONE: done=1 for one cycle -> IDLE. cell_cnt holds its value until the next start.
  - ERROR: all enables 0, error=1. start -> INIT, which clears error. Otherwise error stays asserted.
- start is ignored outside IDLE and ERROR.
- abort from any non-IDLE state -> IDLE next cycle, with no done pulse.
- Watchdog:
  - Counts cycles spent in INIT, READ or TRACE; clears on every state change.
  - When it reaches TIMEOUT-1 without the exit flag, the FSM goes to ERROR.
- Priority when events coincide: rst > abort > watchdog/consistency error > normal transition.
- Status flags are level-sampled; a flag arriving outside its waiting state is ignored.
- Per cell: WRITE and NEXT are each one cycle, so the minimum cell period is 3 cycles (READ with calculated already high).
- A full run issues N*N we pulses and N*N-1 change_index pulses.

Optional Feature:
NW_CTRL_CYCLE_COUNT_EN
- Defined:
  - cycle_count clears on the start edge and increments every cycle while busy=1.
  - It freezes in DONE and ERROR and saturates at 2^32-1.
- Undefined: no counter is built and cycle_count is tied to 0.

Test Plan:
- N=2, start pulse, end_init after 3 cycles, calculated always 1, end_filling on the 4th WRITE, end_c after 5 TRACE cycles -> 4 we pulses, 3 change_index pulses, cell_cnt=4, one done pulse, error=0, busy falls with done.
- N=2, end_filling asserted on the 2nd WRITE -> ERROR; error=1 sticky, all enables 0; a later start clears error and en_init rises.
- TIMEOUT=16, end_init held 0 -> ERROR after 16 INIT cycles, en_init drops to 0.
- abort asserted mid-fill, in READ, at cell 2 -> next cycle state=IDLE, all outputs 0, no done; start pulses during the run are ignored.
- rst asserted during TRACE -> next cycle all outputs 0 and cell_cnt=0; a new start reruns cleanly.
- With NW_CTRL_CYCLE_COUNT_EN, N=2 and the stimulus of the first scenario -> cycle_count equals the number of busy cycles, and is unchanged for 10 idle cycles afterwards; without the macro it reads 0.

Source files
------------

// File: rtl/nw_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : nw_control_unit
// Brief    : Moore sequencer for the Needleman-Wunsch datapath (init, fill,
//            traceback, done) with phase watchdog and cell-count check.
//            Define NW_CTRL_CYCLE_COUNT_EN to build the run cycle counter.
// Revision : 1.0
// ============================================================================
module nw_control_unit #(
    parameter int N       = 128,
    parameter int TIMEOUT = 1024,
    parameter int CELL_W  = $clog2(N*N+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              end_init,
    input  logic              calculated,
    input  logic              end_filling,
    input  logic              end_c,
    output logic              en_init,
    output logic              en_read,
    output logic              en_ins,
    output logic              we,
    output logic              change_index,
    output logic              en_traceB,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CELL_W-1:0] cell_cnt,
    output logic [31:0]       cycle_count
);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] c_s_idle  = 3'd0;
    localparam logic [2:0] c_s_init  = 3'd1;
    localparam logic [2:0] c_s_read  = 3'd2;
    localparam logic [2:0] c_s_write = 3'd3;
    localparam logic [2:0] c_s_next  = 3'd4;
    localparam logic [2:0] c_s_trace = 3'd5;
    localparam logic [2:0] c_s_done  = 3'd6;
    localparam logic [2:0] c_s_error = 3'd7;

    localparam logic [CELL_W-1:0] c_cells   = CELL_W'(N*N);
    localparam logic [WD_W-1:0]   c_wd_last = WD_W'(TIMEOUT-1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [CELL_W-1:0] r_cell_cnt;
    logic [WD_W-1:0]   r_wdog;
    logic              r_error;
    logic              r_en_init, r_en_read, r_en_ins, r_we;
    logic              r_change_index, r_en_traceB, r_busy, r_done;
    logic              w_wait_state;
    logic              w_wd_expired;
    logic              w_start_run;
    logic              w_next_busy;

    assign w_wait_state = (r_state == c_s_init) || (r_state == c_s_read) ||
                          (r_state == c_s_trace);
    assign w_wd_expired = w_wait_state && (r_wdog == c_wd_last);
    assign w_start_run  = (w_next == c_s_init) && (r_state != c_s_init);
    assign w_next_busy  = (w_next == c_s_init)  || (w_next == c_s_read) ||
                          (w_next == c_s_write) || (w_next == c_s_next) ||
                          (w_next == c_s_trace);

    // Exit flag beats the watchdog when both land on the last allowed cycle.
    always_comb begin
        w_next = r_state;
        if (abort && (r_state != c_s_idle)) begin
            w_next = c_s_idle;
        end else begin
            case (r_state)
                c_s_idle:  if (start) w_next = c_s_init;
                c_s_init:  if (end_init) w_next = c_s_read;
                           else if (w_wd_expired) w_next = c_s_error;
                c_s_read:  if (calculated) w_next = c_s_write;
                           else if (w_wd_expired) w_next = c_s_error;
                c_s_write: if (end_filling)
                               w_next = (r_cell_cnt + CELL_W'(1) == c_cells) ? c_s_trace : c_s_error;
                           else
                               w_next = c_s_next;
                c_s_next:  w_next = (r_cell_cnt == c_cells) ? c_s_error : c_s_read;
                c_s_trace: if (end_c) w_next = c_s_done;
                           else if (w_wd_expired) w_next = c_s_error;
                c_s_done:  w_next = c_s_idle;
                c_s_error: if (start) w_next = c_s_init;
                default:   w_next = c_s_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_s_idle;
            r_cell_cnt     <= '0;
            r_wdog         <= '0;
            r_error        <= 1'b0;
            r_en_init      <= 1'b0;
            r_en_read      <= 1'b0;
            r_en_ins       <= 1'b0;
            r_we           <= 1'b0;
            r_change_index <= 1'b0;
            r_en_traceB    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_start_run)
                r_cell_cnt <= '0;
            else if (r_state == c_s_write)
                r_cell_cnt <= r_cell_cnt + CELL_W'(1);

            if ((w_next != r_state) || !w_wait_state)
                r_wdog <= '0;
            else
                r_wdog <= r_wdog + WD_W'(1);

            if (w_start_run)
                r_error <= 1'b0;
            else if (w_next == c_s_error)
                r_error <= 1'b1;

            // Outputs registered from the next state so they equal a decode of r_state.
            r_en_init      <= (w_next == c_s_init);
            r_en_read      <= (w_next == c_s_read);
            r_en_ins       <= (w_next == c_s_write);
            r_we           <= (w_next == c_s_write);
            r_change_index <= (w_next == c_s_next);
            r_en_traceB    <= (w_next == c_s_trace);
            r_busy         <= w_next_busy;
            r_done         <= (w_next == c_s_done);
        end
    end

    assign en_init      = r_en_init;
    assign en_read      = r_en_read;
    assign en_ins       = r_en_ins;
    assign we           = r_we;
    assign change_index = r_change_index;
    assign en_traceB    = r_en_traceB;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign cell_cnt     = r_cell_cnt;

`ifdef NW_CTRL_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_cycle_count <= '0;
        else if (w_start_run)
            r_cycle_count <= '0;
        else if (r_busy && (r_cycle_count != 32'hFFFF_FFFF))
            r_cycle_count <= r_cycle_count + 32'd1;
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nw_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_nw_control_unit
// Brief    : Vector table, directed corner sequences and random stimulus
//            against a phase-level model of the NW sequencer (N=2, TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_nw_control_unit;
    localparam int N       = 2;
    localparam int TIMEOUT = 16;
    localparam int CELL_W  = $clog2(N*N+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, start = 1'b0, abort = 1'b0, end_init = 1'b0;
    logic calculated = 1'b0, end_filling = 1'b0, end_c = 1'b0;
    logic en_init, en_read, en_ins, we, change_index, en_traceB, busy, done, error;
    logic [CELL_W-1:0] cell_cnt;
    logic [31:0]       cycle_count;

    nw_control_unit #(.N(N), .TIMEOUT(TIMEOUT), .CELL_W(CELL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .end_init(end_init),
        .calculated(calculated), .end_filling(end_filling), .end_c(end_c),
        .en_init(en_init), .en_read(en_read), .en_ins(en_ins), .we(we),
        .change_index(change_index), .en_traceB(en_traceB), .busy(busy),
        .done(done), .error(error), .cell_cnt(cell_cnt), .cycle_count(cycle_count)
    );

    int total = 0;
    int bad   = 0;
    int we_pulses, ci_pulses, busy_cycles;

    // Phase-level model of the sequencer.
    typedef enum {P_IDLE, P_INIT, P_READ, P_WRITE, P_NEXT, P_TRACE, P_DONE, P_ERR} phase_t;
    phase_t  m_phase = P_IDLE;
    int      m_cells = 0;
    int      m_wait  = 0;
    bit      m_err   = 1'b0;
    longint  m_cyc   = 0;

    function automatic bit is_busy(input phase_t p);
        return (p == P_INIT) || (p == P_READ) || (p == P_WRITE) || (p == P_NEXT) || (p == P_TRACE);
    endfunction

    task automatic model_step();
        phase_t nxt;
        bit     new_run;
        if (rst) begin
            m_phase = P_IDLE; m_cells = 0; m_wait = 0; m_err = 1'b0; m_cyc = 0;
            return;
        end
        nxt = m_phase;
        if (abort && m_phase != P_IDLE) nxt = P_IDLE;
        else begin
            case (m_phase)
                P_IDLE, P_ERR: if (start) nxt = P_INIT;
                P_INIT:  nxt = end_init    ? P_READ  : (m_wait == TIMEOUT-1 ? P_ERR : P_INIT);
                P_READ:  nxt = calculated  ? P_WRITE : (m_wait == TIMEOUT-1 ? P_ERR : P_READ);
                P_WRITE: nxt = end_filling ? ((m_cells + 1 == N*N) ? P_TRACE : P_ERR) : P_NEXT;
                P_NEXT:  nxt = (m_cells == N*N) ? P_ERR : P_READ;
                P_TRACE: nxt = end_c       ? P_DONE  : (m_wait == TIMEOUT-1 ? P_ERR : P_TRACE);
                P_DONE:  nxt = P_IDLE;
                default: nxt = P_IDLE;
            endcase
        end
        new_run = (nxt == P_INIT) && (m_phase != P_INIT);
        if (new_run) m_cyc = 0;
        else if (is_busy(m_phase) && m_cyc < 64'hFFFF_FFFF) m_cyc++;
        if (m_phase == P_WRITE) m_cells++;
        if (new_run) begin m_cells = 0; m_err = 1'b0; end
        if (nxt == P_ERR) m_err = 1'b1;
        m_wait  = (nxt == m_phase) ? m_wait + 1 : 0;
        m_phase = nxt;
    endtask

    // Flag order: en_init en_read en_ins we change_index en_traceB busy done error
    function automatic logic [8:0] model_flags();
        logic [8:0] f;
        f = '0;
        f[8] = (m_phase == P_INIT);
        f[7] = (m_phase == P_READ);
        f[6] = (m_phase == P_WRITE);
        f[5] = (m_phase == P_WRITE);
        f[4] = (m_phase == P_NEXT);
        f[3] = (m_phase == P_TRACE);
        f[2] = is_busy(m_phase);
        f[1] = (m_phase == P_DONE);
        f[0] = m_err;
        return f;
    endfunction

    function automatic logic [8:0] dut_flags();
        return {en_init, en_read, en_ins, we, change_index, en_traceB, busy, done, error};
    endfunction

    function automatic logic [31:0] model_cycle_count();
`ifdef NW_CTRL_CYCLE_COUNT_EN
        return m_cyc[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {rst, start, abort, end_init, calculated, end_filling, end_c} = v;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_flags", dut_flags(), model_flags());
        check("model_cell_cnt", cell_cnt, m_cells);
        check("model_cycle_count", cycle_count, model_cycle_count());
        if (we) we_pulses++;
        if (change_index) ci_pulses++;
        if (busy) busy_cycles++;
    endtask

    // Inputs order: rst start abort end_init calculated end_filling end_c
    typedef struct {
        logic [6:0] in;
        logic [8:0] out;
        int         cnt;
    } vec_t;
    vec_t tbl[$];

    localparam logic [8:0] F_IDLE  = 9'b000000000;
    localparam logic [8:0] F_INIT  = 9'b100000100;
    localparam logic [8:0] F_READ  = 9'b010000100;
    localparam logic [8:0] F_WRITE = 9'b001100100;
    localparam logic [8:0] F_NEXT  = 9'b000010100;
    localparam logic [8:0] F_TRACE = 9'b000001100;
    localparam logic [8:0] F_DONE  = 9'b000000010;
    localparam logic [6:0] I_CALC  = 7'b0000100;

    task automatic add(input logic [6:0] in, input logic [8:0] out, input int cnt);
        vec_t v;
        v.in = in; v.out = out; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic build_table();
        tbl.delete();
        add(7'b1000000, F_IDLE, 0);
        add(7'b0100000, F_INIT, 0);
        add(I_CALC,     F_INIT, 0);
        add(I_CALC,     F_INIT, 0);
        add(7'b0001100, F_READ, 0);
        for (int c = 0; c < 4; c++) begin
            add(I_CALC, F_WRITE, c);
            if (c < 3) begin
                add(I_CALC, F_NEXT, c + 1);
                add(I_CALC, F_READ, c + 1);
            end
        end
        add(7'b0000110, F_TRACE, 4);
        for (int k = 0; k < 4; k++) add(I_CALC, F_TRACE, 4);
        add(7'b0000101, F_DONE, 4);
        add(I_CALC,     F_IDLE, 4);
    endtask

    // Apply the nominal run; when cut_row >= 0, reset replaces that row's inputs.
    task automatic run_table(input int cut_row);
        we_pulses = 0; ci_pulses = 0; busy_cycles = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == cut_row) begin
                drive(7'b1000000);
                tick();
                check("rst_in_trace_flags", dut_flags(), F_IDLE);
                check("rst_in_trace_cnt", cell_cnt, 0);
                return;
            end
            drive(tbl[i].in);
            tick();
            check($sformatf("vec%0d_flags", i), dut_flags(), tbl[i].out);
            check($sformatf("vec%0d_cnt", i), cell_cnt, tbl[i].cnt);
        end
    endtask

    initial begin
        logic [8:0]  f;
        logic [31:0] cc_hold;
        logic [31:0] cc_exp;

        build_table();

        // Nominal run.
        run_table(-1);
        check("we_pulses", we_pulses, N*N);
        check("change_index_pulses", ci_pulses, N*N-1);
`ifdef NW_CTRL_CYCLE_COUNT_EN
        cc_exp = busy_cycles;
`else
        cc_exp = 32'd0;
`endif
        check("cycle_count_run", cycle_count, cc_exp);
        cc_hold = cycle_count;
        drive(7'b0000000);
        repeat (10) tick();
        check("cycle_count_idle_hold", cycle_count, cc_hold);

        // end_filling arrives early: consistency error, sticky until start.
        drive(7'b0100000); tick();
        drive(7'b0001100); tick();
        drive(I_CALC); tick(); tick(); tick(); tick();
        drive(7'b0000110); tick();
        check("early_fill_error", error, 1'b1);
        f = dut_flags();
        check("early_fill_enables_off", f[8:3], 6'b0);
        for (int k = 0; k < 5; k++) begin
            drive({3'b000, 4'($urandom)});
            tick();
            check("error_sticky", error, 1'b1);
            f = dut_flags();
            check("error_enables_off", f[8:3], 6'b0);
        end
        drive(7'b0100000); tick();
        check("restart_en_init", en_init, 1'b1);
        check("restart_error_clear", error, 1'b0);
        drive(7'b0010000); tick();

        // Watchdog in INIT: 16 cycles of en_init, then error.
        drive(7'b0100000); tick();
        check("wd_init_first", en_init, 1'b1);
        drive(7'b0000000);
        for (int k = 0; k < TIMEOUT-1; k++) begin
            tick();
            check("wd_init_hold", en_init, 1'b1);
        end
        tick();
        check("wd_en_init_drop", en_init, 1'b0);
        check("wd_error", error, 1'b1);
        drive(7'b0010000); tick();

        // Abort in READ at cell 2 while start is toggled and ignored.
        drive(7'b0100000); tick();
        drive(7'b0001100); tick();
        for (int k = 0; k < 6; k++) begin
            drive({1'b0, 1'($urandom), 5'b00100});
            tick();
        end
        check("abort_pre_read", en_read, 1'b1);
        check("abort_pre_cnt", cell_cnt, 2);
        drive(7'b0010100); tick();
        f = dut_flags();
        check("abort_flags_zero", f, F_IDLE);
        check("abort_no_done", done, 1'b0);
        drive(7'b0000000); tick();

        // Reset during TRACE, then a clean rerun.
        run_table(17);
        run_table(-1);
        check("rerun_we_pulses", we_pulses, N*N);
        check("rerun_ci_pulses", ci_pulses, N*N-1);

        // Random stimulus against the model.
        for (int k = 0; k < 3000; k++) begin
            rst         = ($urandom_range(0, 99) == 0);
            start       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 49) == 0);
            end_init    = ($urandom_range(0, 2) == 0);
            calculated  = ($urandom_range(0, 1) == 0);
            end_filling = ($urandom_range(0, 3) == 0);
            end_c       = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
